// File: rtl/fft_output_serializer_pkg.sv
// Shared FFT constants and the read-side state encoding used by the output serializer.
package fft_output_serializer_pkg;

   localparam int FFT_DATA_W   = 16;
   localparam int FFT_N_POINTS = 8;
   localparam int FFT_IDX_W    = $clog2(FFT_N_POINTS);

   typedef logic [FFT_IDX_W-1:0] bin_idx_t;

   typedef enum logic {
      RD_IDLE   = 1'b0,
      RD_STREAM = 1'b1
   } rd_state_t;

endpackage

// File: rtl/fft_output_serializer_if.sv
// Serial FFT bin stream: valid/ready handshake carrying one complex bin per transfer.
interface fft_output_serializer_if
   import fft_output_serializer_pkg::*;
#(
   parameter int DATA_W = FFT_DATA_W
) ();

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_real;
   logic [DATA_W-1:0] out_imag;
   bin_idx_t          out_index;
   logic              out_last;

   modport master (
      output out_valid, out_real, out_imag, out_index, out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_real, out_imag, out_index, out_last,
      output out_ready
   );

endinterface

// File: rtl/fft_output_serializer_frame_slot.sv
// One frame slot: 8 real + 8 imag words loaded in a single cycle, read one bin at a time.
module fft_frame_slot
   import fft_output_serializer_pkg::*;
#(
   parameter int DATA_W = FFT_DATA_W
) (
   input  logic              clk,
   input  logic              load,
   input  logic [DATA_W-1:0] wr_real [FFT_N_POINTS],
   input  logic [DATA_W-1:0] wr_imag [FFT_N_POINTS],
   input  bin_idx_t          rd_idx,
   output logic [DATA_W-1:0] rd_real,
   output logic [DATA_W-1:0] rd_imag
);

   logic [DATA_W-1:0] real_q [FFT_N_POINTS];
   logic [DATA_W-1:0] imag_q [FFT_N_POINTS];

   // Contents are only ever read after a load, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (load) begin
         for (int k = 0; k < FFT_N_POINTS; k++) begin
            real_q[k] <= wr_real[k];
            imag_q[k] <= wr_imag[k];
         end
      end
   end

   assign rd_real = real_q[rd_idx];
   assign rd_imag = imag_q[rd_idx];

endmodule

// File: rtl/fft_output_serializer.sv
// Ping-pong capture of a parallel 8-bin FFT frame, streamed out one bin per transfer.
// Idle capture shows bin 0 the next cycle; outputs hold while out_ready is low; a third frame is dropped.
module fft_output_serializer
   import fft_output_serializer_pkg::*;
#(
   parameter int DATA_W   = FFT_DATA_W,
   parameter int N_POINTS = FFT_N_POINTS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] fft_real0,
   input  logic [DATA_W-1:0] fft_real1,
   input  logic [DATA_W-1:0] fft_real2,
   input  logic [DATA_W-1:0] fft_real3,
   input  logic [DATA_W-1:0] fft_real4,
   input  logic [DATA_W-1:0] fft_real5,
   input  logic [DATA_W-1:0] fft_real6,
   input  logic [DATA_W-1:0] fft_real7,
   input  logic [DATA_W-1:0] fft_imag0,
   input  logic [DATA_W-1:0] fft_imag1,
   input  logic [DATA_W-1:0] fft_imag2,
   input  logic [DATA_W-1:0] fft_imag3,
   input  logic [DATA_W-1:0] fft_imag4,
   input  logic [DATA_W-1:0] fft_imag5,
   input  logic [DATA_W-1:0] fft_imag6,
   input  logic [DATA_W-1:0] fft_imag7,
   input  logic              fft_ready_flag,
   input  logic              clr_overrun,
   output logic              overrun,
   fft_output_serializer_if.master out_bus
);

   localparam bin_idx_t LAST_BIN = bin_idx_t'(N_POINTS - 1);

   logic [DATA_W-1:0] bin_real [FFT_N_POINTS];
   logic [DATA_W-1:0] bin_imag [FFT_N_POINTS];

   assign bin_real[0] = fft_real0;  assign bin_imag[0] = fft_imag0;
   assign bin_real[1] = fft_real1;  assign bin_imag[1] = fft_imag1;
   assign bin_real[2] = fft_real2;  assign bin_imag[2] = fft_imag2;
   assign bin_real[3] = fft_real3;  assign bin_imag[3] = fft_imag3;
   assign bin_real[4] = fft_real4;  assign bin_imag[4] = fft_imag4;
   assign bin_real[5] = fft_real5;  assign bin_imag[5] = fft_imag5;
   assign bin_real[6] = fft_real6;  assign bin_imag[6] = fft_imag6;
   assign bin_real[7] = fft_real7;  assign bin_imag[7] = fft_imag7;

   rd_state_t         state, state_nxt;
   logic              ready_q;
   logic [1:0]        full;
   logic              wr_ptr, rd_ptr;
   logic              capture, accept, drop, xfer, frame_done;
   logic [1:0]        slot_load;
   logic [DATA_W-1:0] slot_real [2];
   logic [DATA_W-1:0] slot_imag [2];

   logic              load_out, nxt_valid, nxt_bypass, nxt_sel;
   bin_idx_t          nxt_idx;

   assign capture    = fft_ready_flag && !ready_q;
   assign xfer       = out_bus.out_valid && out_bus.out_ready;
   assign frame_done = xfer && (out_bus.out_index == LAST_BIN);
   // With both slots full, the slot finishing this cycle is the write target.
   assign accept     = capture && (!full[wr_ptr] || (frame_done && (rd_ptr == wr_ptr)));
   assign drop       = capture && !accept;
   assign slot_load  = {accept && wr_ptr, accept && !wr_ptr};

   fft_frame_slot #(.DATA_W(DATA_W)) u_slot0 (
      .clk     (clk),
      .load    (slot_load[0]),
      .wr_real (bin_real),
      .wr_imag (bin_imag),
      .rd_idx  (nxt_idx),
      .rd_real (slot_real[0]),
      .rd_imag (slot_imag[0])
   );

   fft_frame_slot #(.DATA_W(DATA_W)) u_slot1 (
      .clk     (clk),
      .load    (slot_load[1]),
      .wr_real (bin_real),
      .wr_imag (bin_imag),
      .rd_idx  (nxt_idx),
      .rd_real (slot_real[1]),
      .rd_imag (slot_imag[1])
   );

   always_ff @(posedge clk) begin
      if (rst) state <= RD_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RD_IDLE:   if (|full || accept) state_nxt = RD_STREAM;
         RD_STREAM: if (frame_done && !full[~rd_ptr] && !accept) state_nxt = RD_IDLE;
         default:   state_nxt = RD_IDLE;
      endcase
   end

   // Selects what the output register holds next; a frame captured this very
   // cycle is taken straight from the inputs since its slot is not yet written.
   always_comb begin
      load_out   = 1'b0;
      nxt_valid  = 1'b0;
      nxt_bypass = 1'b0;
      nxt_sel    = rd_ptr;
      nxt_idx    = '0;
      case (state)
         RD_IDLE: begin
            if (|full) begin
               load_out  = 1'b1;
               nxt_valid = 1'b1;
            end else if (accept) begin
               load_out   = 1'b1;
               nxt_valid  = 1'b1;
               nxt_bypass = 1'b1;
            end
         end
         RD_STREAM: begin
            if (xfer) begin
               load_out = 1'b1;
               if (!frame_done) begin
                  nxt_valid = 1'b1;
                  nxt_idx   = out_bus.out_index + bin_idx_t'(1);
               end else if (full[~rd_ptr]) begin
                  nxt_valid = 1'b1;
                  nxt_sel   = ~rd_ptr;
               end else if (accept) begin
                  nxt_valid  = 1'b1;
                  nxt_bypass = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_bus.out_valid <= 1'b0;
         out_bus.out_index <= '0;
         out_bus.out_last  <= 1'b0;
         out_bus.out_real  <= '0;
         out_bus.out_imag  <= '0;
      end else if (load_out) begin
         out_bus.out_valid <= nxt_valid;
         out_bus.out_index <= nxt_idx;
         out_bus.out_last  <= nxt_valid && (nxt_idx == LAST_BIN);
         out_bus.out_real  <= !nxt_valid ? '0 : (nxt_bypass ? bin_real[0] : slot_real[nxt_sel]);
         out_bus.out_imag  <= !nxt_valid ? '0 : (nxt_bypass ? bin_imag[0] : slot_imag[nxt_sel]);
      end
   end

   // Free before fill so a slot finishing and refilling in one cycle stays full.
   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q <= 1'b0;
         full    <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         overrun <= 1'b0;
      end else begin
         ready_q <= fft_ready_flag;
         if (frame_done) begin
            full[rd_ptr] <= 1'b0;
            rd_ptr       <= ~rd_ptr;
         end
         if (accept) begin
            full[wr_ptr] <= 1'b1;
            wr_ptr       <= ~wr_ptr;
         end
         if (drop)             overrun <= 1'b1;
         else if (clr_overrun) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fft_output_serializer.sv
// Directed bench: per-cycle vector tables plus hand-written overrun and mid-stream reset sequences.
module tb_fft_output_serializer;

   localparam int DW = 16;

   typedef struct {
      logic ready;
      logic flag;
      int   sel;
      logic exp_valid;
      int   exp_idx;
      int   exp_sel;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] fft_real [8];
   logic [DW-1:0] fft_imag [8];
   logic          fft_ready_flag = 1'b0;
   logic          clr_overrun = 1'b0;
   logic          overrun;

   int   n_checks = 0;
   int   n_errors = 0;
   vec_t vq[$];

   fft_output_serializer_if #(.DATA_W(DW)) out_bus ();

   fft_output_serializer #(.DATA_W(DW), .N_POINTS(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .fft_real0      (fft_real[0]),
      .fft_real1      (fft_real[1]),
      .fft_real2      (fft_real[2]),
      .fft_real3      (fft_real[3]),
      .fft_real4      (fft_real[4]),
      .fft_real5      (fft_real[5]),
      .fft_real6      (fft_real[6]),
      .fft_real7      (fft_real[7]),
      .fft_imag0      (fft_imag[0]),
      .fft_imag1      (fft_imag[1]),
      .fft_imag2      (fft_imag[2]),
      .fft_imag3      (fft_imag[3]),
      .fft_imag4      (fft_imag[4]),
      .fft_imag5      (fft_imag[5]),
      .fft_imag6      (fft_imag[6]),
      .fft_imag7      (fft_imag[7]),
      .fft_ready_flag (fft_ready_flag),
      .clr_overrun    (clr_overrun),
      .overrun        (overrun),
      .out_bus        (out_bus)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] frame_real(input int sel, input int k);
      case (sel)
         0:       frame_real = DW'(k + 1);
         default: frame_real = DW'(sel * 256 + k);
      endcase
   endfunction

   function automatic logic [DW-1:0] frame_imag(input int sel, input int k);
      case (sel)
         0:       frame_imag = DW'(-(k + 1));
         default: frame_imag = DW'(16'h8000 + sel * 256 + k);
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_frame(input int sel);
      for (int k = 0; k < 8; k++) begin
         fft_real[k] = frame_real(sel, k);
         fft_imag[k] = frame_imag(sel, k);
      end
   endtask

   task automatic add(input logic rdy, input logic flg, input int sel,
                      input logic ev, input int eidx, input int esel);
      vec_t v;
      v.ready = rdy; v.flag = flg; v.sel = sel;
      v.exp_valid = ev; v.exp_idx = eidx; v.exp_sel = esel;
      vq.push_back(v);
   endtask

   task automatic check_bin(input string tag, input int idx, input int sel);
      check({tag, " valid"}, 32'(out_bus.out_valid), 32'd1);
      check({tag, " index"}, 32'(out_bus.out_index), 32'(idx));
      check({tag, " real"},  32'(out_bus.out_real),  32'(frame_real(sel, idx)));
      check({tag, " imag"},  32'(out_bus.out_imag),  32'(frame_imag(sel, idx)));
      check({tag, " last"},  32'(out_bus.out_last),  32'(idx == 7));
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < vq.size(); i++) begin
         out_bus.out_ready = vq[i].ready;
         fft_ready_flag    = vq[i].flag;
         if (vq[i].flag) drive_frame(vq[i].sel);
         if (vq[i].exp_valid)
            check_bin($sformatf("%s[%0d]", tag, i), vq[i].exp_idx, vq[i].exp_sel);
         else
            check($sformatf("%s[%0d] valid", tag, i), 32'(out_bus.out_valid), 32'd0);
         step();
      end
      vq.delete();
   endtask

   initial begin
      out_bus.out_ready = 1'b0;
      drive_frame(0);

      // Reset state
      step(); step();
      check("rst valid", 32'(out_bus.out_valid), 32'd0);
      check("rst last",  32'(out_bus.out_last),  32'd0);
      check("rst real",  32'(out_bus.out_real),  32'd0);
      check("rst imag",  32'(out_bus.out_imag),  32'd0);
      check("rst index", 32'(out_bus.out_index), 32'd0);
      check("rst overrun", 32'(overrun), 32'd0);
      rst = 1'b0;
      step();

      // Single frame, full throughput
      add(1, 1, 0, 0, 0, 0);
      for (int c = 1; c <= 8; c++) add(1, 0, 0, 1, c - 1, 0);
      add(1, 0, 0, 0, 0, 0);
      run_table("single");

      // Backpressure: ready 0,1,0,1... every bin shown for two cycles
      add(0, 1, 0, 0, 0, 0);
      for (int c = 1; c <= 16; c++) add(c % 2 == 0, 0, 0, 1, (c - 1) / 2, 0);
      add(1, 0, 0, 0, 0, 0);
      run_table("bp");

      // Back-to-back frames captured two cycles apart
      add(1, 1, 1, 0, 0, 0);
      add(1, 0, 1, 1, 0, 1);
      add(1, 1, 2, 1, 1, 1);
      for (int c = 3; c <= 8; c++)  add(1, 0, 2, 1, c - 1, 1);
      for (int c = 9; c <= 16; c++) add(1, 0, 2, 1, c - 9, 2);
      add(1, 0, 2, 0, 0, 0);
      run_table("b2b");

      // Level held high for 20 cycles captures once
      add(1, 1, 1, 0, 0, 0);
      for (int c = 1; c <= 8; c++)   add(1, 1, 1, 1, c - 1, 1);
      for (int c = 9; c <= 19; c++)  add(1, 1, 1, 0, 0, 0);
      add(1, 0, 1, 0, 0, 0);
      add(1, 0, 1, 0, 0, 0);
      run_table("hold");

      // Overrun: two frames held, third dropped while clr_overrun is also high
      out_bus.out_ready = 1'b0;
      drive_frame(1); fft_ready_flag = 1'b1; step();
      fft_ready_flag = 1'b0; step();
      drive_frame(2); fft_ready_flag = 1'b1; step();
      fft_ready_flag = 1'b0; step();
      check("ovr before drop", 32'(overrun), 32'd0);
      drive_frame(3); fft_ready_flag = 1'b1; clr_overrun = 1'b1; step();
      fft_ready_flag = 1'b0;
      check("ovr set wins", 32'(overrun), 32'd1);
      check_bin("ovr stalled", 0, 1);
      step();
      clr_overrun = 1'b0;
      check("ovr cleared", 32'(overrun), 32'd0);
      // Release: frames 1,2 stream; a capture lands on frame 1's last bin with both slots full
      out_bus.out_ready = 1'b1;
      for (int i = 0; i < 24; i++) begin
         check_bin($sformatf("ovr_stream[%0d]", i), i % 8, (i < 8) ? 1 : ((i < 16) ? 2 : 4));
         check($sformatf("ovr_stream[%0d] overrun", i), 32'(overrun), 32'd0);
         if (i == 7) begin
            drive_frame(4);
            fft_ready_flag = 1'b1;
         end else begin
            fft_ready_flag = 1'b0;
         end
         step();
      end
      check("ovr end valid", 32'(out_bus.out_valid), 32'd0);

      // Reset mid-stream discards the partial frame and the queued one
      drive_frame(1); fft_ready_flag = 1'b1; step();
      fft_ready_flag = 1'b0;
      check_bin("mid bin0", 0, 1);
      step();
      drive_frame(2); fft_ready_flag = 1'b1;
      check_bin("mid bin1", 1, 1);
      step();
      fft_ready_flag = 1'b0;
      step();
      check_bin("mid bin3", 3, 1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid rst valid", 32'(out_bus.out_valid), 32'd0);
      check("mid rst last",  32'(out_bus.out_last),  32'd0);
      check("mid rst index", 32'(out_bus.out_index), 32'd0);
      check("mid rst real",  32'(out_bus.out_real),  32'd0);
      for (int i = 0; i < 10; i++) begin
         step();
         check($sformatf("mid quiet[%0d]", i), 32'(out_bus.out_valid), 32'd0);
      end
      drive_frame(3); fft_ready_flag = 1'b1; step();
      fft_ready_flag = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check_bin($sformatf("mid restart[%0d]", i), i, 3);
         step();
      end
      check("mid restart end", 32'(out_bus.out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
